// File: rtl/sqr_wav_meas.sv
// Square-wave period measurer: times each high and low phase of sqr_in in
// CLK_PER_UNIT-clock units and reports both after every full period.
//
//   state | meaning
//   ACQ   | waiting for a rise to start a clean period (reset / after stall)
//   HIGH  | timing the high phase, waiting for fall
//   LOW   | timing the low phase, waiting for rise to report the period
module sqr_wav_meas #(
    parameter int CLK_PER_UNIT  = 10,
    parameter int CNT_W         = 8,
    parameter int TIMEOUT_UNITS = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sqr_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             stuck
);

    localparam int PS_W = $clog2(CLK_PER_UNIT);
    localparam int UN_W = $clog2(TIMEOUT_UNITS + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_UNIT - 1);
    localparam logic [UN_W-1:0] UN_TO   = UN_W'(TIMEOUT_UNITS);
    localparam logic [UN_W-1:0] UN_PRE  = UN_W'(TIMEOUT_UNITS - 1);
    localparam logic [UN_W-1:0] SAT     = UN_W'((2 ** CNT_W) - 1);

    typedef enum logic [1:0] {ACQ, HIGH, LOW} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              s1, s2, s3;
    logic              rise, fall, any_edge;
    logic [PS_W-1:0]   presc;
    logic [UN_W-1:0]   unit_cnt;
    logic              presc_last;
    logic              timeout;
    logic [UN_W-1:0]   phase_units;
    logic [CNT_W-1:0]  phase_sat;
    logic [CNT_W-1:0]  high_len;
    logic              hold_ld;
    logic              report;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sqr_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign any_edge   = rise | fall;
    assign presc_last = (presc == PS_LAST);
    assign timeout    = ~any_edge & presc_last & (unit_cnt == UN_PRE);

    // Counters restart after the edge cycle, so the edge cycle itself is added
    // back here: a phase of L clocks then reads floor(L / CLK_PER_UNIT).
    assign phase_units = unit_cnt + UN_W'(presc_last);
    assign phase_sat   = (phase_units > SAT) ? '1 : phase_units[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            unit_cnt <= '0;
        end else if (any_edge) begin
            presc    <= '0;
            unit_cnt <= '0;
        end else if (presc_last) begin
            presc <= '0;
            if (unit_cnt != UN_TO)
                unit_cnt <= unit_cnt + UN_W'(1);
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ACQ;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hold_ld   = 1'b0;
        report    = 1'b0;
        case (state)
            ACQ: begin
                if (rise)
                    state_nxt = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    hold_ld   = 1'b1;
                    state_nxt = LOW;
                end else if (timeout) begin
                    state_nxt = ACQ;
                end
            end
            LOW: begin
                if (rise) begin
                    report    = 1'b1;
                    state_nxt = HIGH;
                end else if (timeout) begin
                    state_nxt = ACQ;
                end
            end
            default: state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_len   <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= report;
            if (hold_ld)
                high_len <= phase_sat;
            if (report) begin
                high_cnt <= high_len;
                low_cnt  <= phase_sat;
            end
            if (rise)
                stuck <= 1'b0;
            else if (timeout)
                stuck <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sqr_wav_meas.sv
// Bench for sqr_wav_meas: two instances (default and a narrow-count one) share
// one stimulus and are checked every cycle against an edge-timestamp model.
module tb_sqr_wav_meas;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sqr_in = 1'b0;
    logic [7:0] hc0, lc0;
    logic       mv0, st0;
    logic [3:0] hc1, lc1;
    logic       mv1, st1;

    always #5 clk = ~clk;

    sqr_wav_meas dut0 (
        .clk(clk), .reset_n(reset_n), .sqr_in(sqr_in),
        .high_cnt(hc0), .low_cnt(lc0), .meas_valid(mv0), .stuck(st0)
    );

    sqr_wav_meas #(.CLK_PER_UNIT(10), .CNT_W(4), .TIMEOUT_UNITS(100)) dut1 (
        .clk(clk), .reset_n(reset_n), .sqr_in(sqr_in),
        .high_cnt(hc1), .low_cnt(lc1), .meas_valid(mv1), .stuck(st1)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vt[$];

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from the cycle numbers at which input edges are sampled; every
    // consequence of a sample at cycle n is visible after clock edge n+2.
    typedef struct {
        int hc;
        int lc;
        int mv;
        int st;
    } exp_t;

    int   n;
    int   last_edge;
    logic prev_lvl;
    int   rise_t[2];
    int   fall_t[2];
    exp_t cur[2], h1[2], h2[2], e_now[2];

    function automatic int tmo_clk(int i);
        return (i == 0) ? 10000 : 1000;
    endfunction

    function automatic int sat_units(int len, int i);
        int u, mx;
        u  = len / 10;
        mx = (i == 0) ? 255 : 15;
        return (u > mx) ? mx : u;
    endfunction

    task model_reset();
        n = 0;
        last_edge = -2;
        prev_lvl = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rise_t[i] = -1;
            fall_t[i] = -1;
            cur[i]   = '{0, 0, 0, 0};
            h1[i]    = '{0, 0, 0, 0};
            h2[i]    = '{0, 0, 0, 0};
            e_now[i] = '{0, 0, 0, 0};
        end
    endtask

    initial model_reset();

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            logic lvl, edg;
            exp_t r;
            n++;
            lvl = sqr_in;
            edg = (lvl != prev_lvl);
            prev_lvl = lvl;
            for (int i = 0; i < 2; i++) begin
                r = cur[i];
                r.mv = 0;
                if (edg && lvl) begin
                    if (rise_t[i] >= 0 && fall_t[i] >= 0) begin
                        r.hc = sat_units(fall_t[i] - rise_t[i], i);
                        r.lc = sat_units(n - fall_t[i], i);
                        r.mv = 1;
                    end
                    rise_t[i] = n;
                    fall_t[i] = -1;
                    r.st = 0;
                end else if (edg) begin
                    if (rise_t[i] >= 0)
                        fall_t[i] = n;
                end else if (n - last_edge == tmo_clk(i)) begin
                    rise_t[i] = -1;
                    fall_t[i] = -1;
                    r.st = 1;
                end
                cur[i]   = r;
                e_now[i] = h2[i];
                h2[i]    = h1[i];
                h1[i]    = r;
            end
            if (edg)
                last_edge = n;
        end
    end

    always @(negedge clk) begin
        check("d0_high_cnt", int'(hc0), e_now[0].hc);
        check("d0_low_cnt", int'(lc0), e_now[0].lc);
        check("d0_meas_valid", int'(mv0), e_now[0].mv);
        check("d0_stuck", int'(st0), e_now[0].st);
        check("d1_high_cnt", int'(hc1), e_now[1].hc);
        check("d1_low_cnt", int'(lc1), e_now[1].lc);
        check("d1_meas_valid", int'(mv1), e_now[1].mv);
        check("d1_stuck", int'(st1), e_now[1].st);
        if (mv0)
            vt.push_back(cyc);
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic phase(logic lvl, int clocks);
        sqr_in = lvl;
        wait_cyc(clocks);
    endtask

    task automatic neg_at(int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic first_valid_after(string name, int c, int exp);
        int got;
        got = -1;
        foreach (vt[j])
            if (got < 0 && vt[j] > c)
                got = vt[j];
        check(name, got, exp);
    endtask

    initial begin
        int c0, c1, c2, c3, guard, hi, lo;

        // reset held while the input toggles
        repeat (6) begin
            @(posedge clk);
            #1;
            sqr_in = ~sqr_in;
        end
        check("rst_high", int'(hc0), 0);
        check("rst_low", int'(lc0), 0);
        check("rst_stuck", int'(st0), 0);
        sqr_in = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(20);
        check("rel_no_valid", vt.size(), 0);
        check("rel_high", int'(hc0), 0);

        // nominal 30/50
        vt.delete();
        c0 = cyc + 1;
        repeat (6) begin
            phase(1'b1, 30);
            phase(1'b0, 50);
        end
        check("nom_pulses", vt.size(), 5);
        check("nom_first", vt[0], c0 + 82);
        for (int j = 1; j < vt.size(); j++)
            check("nom_gap", vt[j] - vt[j-1], 80);
        check("nom_high", int'(hc0), 3);
        check("nom_low", int'(lc0), 5);

        // rounding and zero-length phase, then a new pattern
        repeat (3) begin
            phase(1'b1, 37);
            phase(1'b0, 9);
        end
        check("rnd_high", int'(hc0), 3);
        check("rnd_low", int'(lc0), 0);
        repeat (2) begin
            phase(1'b1, 10);
            phase(1'b0, 150);
        end
        check("rnd2_high", int'(hc0), 1);
        check("rnd2_low", int'(lc0), 15);

        // saturation on the 4-bit instance
        repeat (2) begin
            phase(1'b1, 200);
            phase(1'b0, 20);
        end
        check("sat_high", int'(hc1), 15);
        check("sat_low", int'(lc1), 2);
        check("sat_stuck", int'(st1), 0);
        check("sat_wide_high", int'(hc0), 20);

        // stall and recovery
        repeat (2) begin
            phase(1'b1, 30);
            phase(1'b0, 50);
        end
        sqr_in = 1'b1;
        c1 = cyc + 1;
        guard = 0;
        while (!st0 && guard < 11000) begin
            @(negedge clk);
            guard++;
        end
        check("stall_seen", int'(st0), 1);
        check("stall_time", cyc, c1 + 10002);
        check("stall_high", int'(hc0), 3);
        check("stall_low", int'(lc0), 5);
        @(posedge clk);
        #1;
        phase(1'b0, 50);
        vt.delete();
        sqr_in = 1'b1;
        c2 = cyc + 1;
        neg_at(c2 + 1);
        check("resume_stuck_held", int'(st0), 1);
        neg_at(c2 + 2);
        check("resume_stuck_clr", int'(st0), 0);
        while (cyc < c2 + 29) begin
            @(posedge clk);
            #1;
        end
        phase(1'b0, 50);
        repeat (2) begin
            phase(1'b1, 30);
            phase(1'b0, 50);
        end
        first_valid_after("resume_first", c2, c2 + 82);
        check("resume_high", int'(hc0), 3);
        check("resume_low", int'(lc0), 5);

        // reset in the middle of a low phase
        phase(1'b1, 20);
        sqr_in = 1'b0;
        wait_cyc(20);
        reset_n = 1'b0;
        #1;
        check("mid_rst_high", int'(hc0), 0);
        check("mid_rst_low", int'(lc0), 0);
        check("mid_rst_valid", int'(mv0), 0);
        check("mid_rst_stuck", int'(st0), 0);
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(3);
        vt.delete();
        c3 = cyc + 1;
        repeat (3) begin
            phase(1'b1, 20);
            phase(1'b0, 40);
        end
        first_valid_after("mid_first", c3, c3 + 62);
        check("mid_high", int'(hc0), 2);
        check("mid_low", int'(lc0), 4);

        // random phases, checked by the model every cycle
        repeat (40) begin
            hi = $urandom_range(1, 150);
            lo = $urandom_range(1, 150);
            phase(1'b1, hi);
            phase(1'b0, lo);
        end
        wait_cyc(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
